wide_add_seq: RTL and testbench

Multi-cycle sequencer that performs NWORDS*8-bit add/subtract by time-multiplexing one 8-bit ripple adder slice (multi_adder), least-significant byte first.
- Carry is registered between slices.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Replaces a full-width adder where area matters more than latency.

---
 rtl/wide_add_pkg.sv | 18 +
 rtl/multi_adder.sv | 25 ++
 rtl/wide_add_seq.sv | 139 +++++++++++++
 tb/tb_wide_add_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and constants for the byte-serial wide add/subtract sequencer.
// The adder datapath is one 8-bit slice, reused once per operand byte.
package wide_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 8;

  // Width of the slice index; never narrower than one bit, so NWORDS=1 still works.
  function automatic int idx_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/multi_adder.sv
// 8-bit ripple-carry adder slice with carry in and carry out.
// It is purely combinational; the sequencer registers the carry between slices.
module multi_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_fa
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[8];

endmodule

// File: rtl/wide_add_seq.sv
// NWORDS*8-bit add/subtract, computed one byte per cycle (LSB first)
// through a single multi_adder slice, with valid/ready handshakes on both sides.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter  int NWORDS = 4,
  localparam int OPW    = SLICE_W * NWORDS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  input  logic           in_sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_sum,
  output logic           out_cout,
  output logic           out_ovf,
  output logic           busy
);

  localparam int IDX_W = idx_width(NWORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

  state_t state_q, state_d;

  logic [OPW-1:0]   a_q, a_d;
  logic [OPW-1:0]   b_q, b_d;
  logic             sub_q, sub_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [OPW-1:0]   result_q, result_d;
  logic             ovf_q, ovf_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               last_slice;
  logic               accept;

  assign last_slice = (idx_q == IDX_LAST);
  assign accept     = (state_q == ST_IDLE) && in_valid;

  // Subtraction is A + ~B + 1: B is inverted here and the +1 enters as the initial carry.
  always_comb begin
    slice_a = a_q[idx_q * SLICE_W +: SLICE_W];
    slice_b = b_q[idx_q * SLICE_W +: SLICE_W] ^ {SLICE_W{sub_q}};
  end

  multi_adder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_RUN;
      ST_RUN:  if (last_slice) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from state or come straight from registers.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    out_sum   = result_q;
    out_cout  = carry_q;
    out_ovf   = ovf_q;
  end

  // Operand, result and carry update.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    if (accept) begin
      a_d     = in_a;
      b_d     = in_b;
      sub_d   = in_sub;
      idx_d   = '0;
      carry_d = in_sub;
      ovf_d   = 1'b0;
    end else if (state_q == ST_RUN) begin
      result_d[idx_q * SLICE_W +: SLICE_W] = slice_sum;
      carry_d = slice_cout;
      idx_d   = idx_q + 1'b1;
      if (last_slice) begin
        // Signed overflow: operands (after inversion) agree in sign but the result does not.
        ovf_d = (a_q[OPW-1] == (b_q[OPW-1] ^ sub_q)) && (slice_sum[SLICE_W-1] != a_q[OPW-1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed, table-driven bench for wide_add_seq at NWORDS=4, plus
// backpressure and asynchronous-reset sequences.
module tb_wide_add_seq;

  localparam int NW  = 4;
  localparam int OPW = 8 * NW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [OPW-1:0] in_a = '0;
  logic [OPW-1:0] in_b = '0;
  logic           in_sub = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [OPW-1:0] out_sum;
  logic           out_cout;
  logic           out_ovf;
  logic           busy;

  int n_cmp  = 0;
  int n_fail = 0;

  wide_add_seq #(.NWORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called #1 after a posedge; the next posedge is the accepting edge.
  task automatic start_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sub);
    chk({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge until out_valid, bounded.
  task automatic wait_result(input string name);
    int lat;
    for (lat = 1; lat <= 20; lat++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) break;
      chk({name, " busy in RUN"}, 32'(busy), 32'd1);
      chk({name, " in_ready in RUN"}, 32'(in_ready), 32'd0);
    end
    chk({name, " latency"}, 32'(lat), 32'(NW));
  endtask

  task automatic check_result(input string name, input logic [31:0] sum, input logic cout,
                              input logic ovf);
    chk({name, " out_valid"}, 32'(out_valid), 32'd1);
    chk({name, " out_sum"}, out_sum, sum);
    chk({name, " out_cout"}, 32'(out_cout), 32'(cout));
    chk({name, " out_ovf"}, 32'(out_ovf), 32'(ovf));
    $display("op %-10s sum=0x%08h cout=%0d ovf=%0d (exp 0x%08h %0d %0d)",
             name, out_sum, out_cout, out_ovf, sum, cout, ovf);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    chk({name, " out_valid after handshake"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[6] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[8] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[9] = '{32'hDEADBEEF, 32'h01010101, 1'b0, 32'hDFAEBFF0, 1'b0, 1'b0};

    // Reset state.
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset out_sum", out_sum, 32'd0);
    chk("reset out_cout", 32'(out_cout), 32'd0);
    chk("reset out_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      start_op(nm, vecs[i].a, vecs[i].b, vecs[i].sub);
      wait_result(nm);
      check_result(nm, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      handshake(nm);
    end

    // Backpressure: new request pending throughout RUN and a stalled DONE.
    start_op("bp", 32'h00010000, 32'h0000FFFF, 1'b0);
    in_valid = 1'b1;
    in_a     = 32'h11111111;
    in_b     = 32'h01010101;
    in_sub   = 1'b1;
    wait_result("bp");
    check_result("bp", 32'h0001FFFF, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp stall out_valid", 32'(out_valid), 32'd1);
      chk("bp stall in_ready", 32'(in_ready), 32'd0);
      chk("bp stall out_sum", out_sum, 32'h0001FFFF);
    end
    handshake("bp");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result("bp2");
    check_result("bp2", 32'h10101010, 1'b1, 1'b0);
    handshake("bp2");

    // Asynchronous reset while idx==2 of RUN.
    start_op("rst", 32'hAAAAAAAA, 32'h55555555, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst out_sum", out_sum, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk("post rst no pulse", 32'(out_valid), 32'd0);
    end
    start_op("postrst", 32'h12345678, 32'h11111111, 1'b0);
    wait_result("postrst");
    check_result("postrst", 32'h23456789, 1'b0, 1'b0);
    handshake("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
